// File: rtl/alu_share_arb_if.sv
// ---------------------------------------------------------------------------
// alu_share_arb_if
// Bundle of the request, response and ALU-side signals of alu_share_arb.
//   slave  : arbiter side (takes requests, drives responses and ALU inputs)
//   master : requesters plus ALU (drive requests/alu_r, take responses)
// Signals:
//   req{0,1}_valid/ready, req{0,1}_a/_b/_op : request handshakes and operands
//   rsp{0,1}_valid/ready, rsp_r, rsp_err     : response handshakes, shared result
//   alu_a, alu_b, alu_op, alu_r              : shared ALU connection
//   busy                                     : arbiter not idle
// ---------------------------------------------------------------------------
interface alu_share_arb_if #(
    parameter int W   = 32,
    parameter int OPW = 4
);
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op;
    logic           rsp0_valid, rsp1_valid;
    logic           rsp0_ready, rsp1_ready;
    logic [W-1:0]   rsp_r;
    logic           rsp_err;
    logic [W-1:0]   alu_a, alu_b;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_r;
    logic           busy;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, rsp0_ready, rsp1_ready, alu_r,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_r,
               rsp_err, alu_a, alu_b, alu_op, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, rsp0_ready, rsp1_ready, alu_r,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_r,
               rsp_err, alu_a, alu_b, alu_op, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: accept (IDLE) -> drive ALU from registers (ISSUE) ->
// hold result until the owner takes it (RESP).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : alu_share_arb_if.slave (request/response handshakes, ALU I/O, busy)
// Build option:
//   ALU_ARB_FIXED_PRIO_EN : requester 0 always wins ties (no round-robin).
//
// state | meaning
// IDLE  | arbitrate, assert ready for the winner, latch operands on accept
// ISSUE | ALU driven from latched operands, result captured at the edge
// RESP  | rsp valid to owner, wait for its ready
// ---------------------------------------------------------------------------
module alu_share_arb #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_share_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OPW-1:0] op_q, op_d;
    logic           owner_q, owner_d;
    logic           ill_q, ill_d;
    logic           err_q, err_d;
    logic           gnt0, gnt1;
    logic [OPW-1:0] op_sel;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // last granted requester; reset to 1 so requester 0 wins the first tie
    logic ptr_q, ptr_d;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !rst) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid && !bus.req0_valid;
`else
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = ptr_q;
                gnt1 = !ptr_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
`endif
        end
    end

    assign op_sel = gnt1 ? bus.req1_op : bus.req0_op;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        owner_d = owner_q;
        ill_d   = ill_q;
        res_d   = res_q;
        err_d   = err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? bus.req1_a : bus.req0_a;
                    b_d     = gnt1 ? bus.req1_b : bus.req0_b;
                    op_d    = op_sel;
                    owner_d = gnt1;
                    ill_d   = (op_sel > OPW'(8));
`ifndef ALU_ARB_FIXED_PRIO_EN
                    ptr_d   = gnt1;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                res_d   = ill_q ? '0 : bus.alu_r;
                err_d   = ill_q;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? bus.rsp1_ready : bus.rsp0_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            owner_q <= 1'b0;
            ill_q   <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            owner_q <= owner_d;
            ill_q   <= ill_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == RESP) && owner_q;
    assign bus.rsp_r      = res_q;
    assign bus.rsp_err    = err_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
    localparam int W   = 32;
    localparam int OPW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arb_if #(.W(W), .OPW(OPW)) bus ();
    alu_share_arb #(.W(W), .OPW(OPW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT.
    // Illegal codes yield a recognisable junk value that must never reach rsp_r.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $signed(a) >>> b[4:0];
            4'd8: return {31'b0, $signed(a) < $signed(b)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction
    assign bus.alu_r = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    typedef struct {
        int          port;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [31:0] r;
        logic        err;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester-side pending transactions (held until accepted) and model state
    bit          pv[2];
    logic [31:0] pa[2], pb[2];
    logic [3:0]  pop[2];
    bit          rr[2];
    int          gen_left[2];
    int          gen      = 0;
    bit          rand_rdy = 0;
    int          hold     = 0;
    int          last     = 1;
    bit          outst    = 0;
    int          ostart   = 0;
    int          oport    = 0;

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        pv[p] = 1; pa[p] = a; pb[p] = b; pop[p] = op;
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (!pv[i] && gen_left[i] > 0) begin
                if (gen == 1) begin
                    gen_left[i]--;
                    if (i == 0) set_req(0, 32'd10, 32'd3, 4'd1);
                    else        set_req(1, 32'hF0, 32'h0F, 4'd3);
                end else if (gen == 2 && $urandom_range(0, 1) == 1) begin
                    gen_left[i]--;
                    set_req(i,
                            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                            4'($urandom_range(0, 15)));
                end
            end
            rr[i] = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (outst && oport == i && hold > 0) rr[i] = (cyc >= ostart + hold);
        end
        bus.req0_valid = pv[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0]; bus.req0_op = pop[0];
        bus.req1_valid = pv[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1]; bus.req1_op = pop[1];
        bus.rsp0_ready = rr[0];
        bus.rsp1_ready = rr[1];
    endtask

    // Model of the arbitration rules plus response timing, evaluated per cycle
    task automatic sample();
        bit   e0, e1;
        exp_t x;
        int   p;
        e0 = 0; e1 = 0;
        if (!rst && !outst) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            e0 = pv[0];
            e1 = pv[1] && !pv[0];
`else
            if (pv[0] && pv[1]) begin
                e0 = (last == 1);
                e1 = (last == 0);
            end else begin
                e0 = pv[0];
                e1 = pv[1];
            end
`endif
        end
        chk1("req0_ready", bus.req0_ready, e0);
        chk1("req1_ready", bus.req1_ready, e1);
        if (!rst) chk1("busy", bus.busy, outst);
        if (e0 || e1) begin
            p     = e1 ? 1 : 0;
            x.port = p; x.a = pa[p]; x.b = pb[p]; x.op = pop[p];
            x.err = (pop[p] > 4'd8);
            x.r   = x.err ? 32'd0 : alu_f(pop[p], pa[p], pb[p]);
            x.acc = cyc;
            sb.push_back(x);
            last   = p;
            pv[p]  = 0;
            outst  = 1;
            ostart = cyc + 2;
            oport  = p;
        end else if (outst && cyc >= ostart && rr[oport]) begin
            outst = 0;
        end
    endtask

    task automatic step_rst(input bit r);
        @(posedge clk);
        #1;
        rst = r;
        if (r) begin
            sb.delete();
            outst = 0;
            last  = 1;
        end
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic step();
        step_rst(1'b0);
    endtask

    function automatic bit model_idle();
        return !outst && !pv[0] && !pv[1] && gen_left[0] == 0 && gen_left[1] == 0;
    endfunction

    task automatic run_until_idle(input string name, input int maxc);
        int n = 0;
        while (!model_idle() && n < maxc) begin
            step();
            n++;
        end
        if (!model_idle()) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, maxc);
        end
        step();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk1({tag, "_req0_ready"}, bus.req0_ready, 1'b0);
        chk1({tag, "_req1_ready"}, bus.req1_ready, 1'b0);
        chk1({tag, "_rsp0_valid"}, bus.rsp0_valid, 1'b0);
        chk1({tag, "_rsp1_valid"}, bus.rsp1_valid, 1'b0);
        chk32({tag, "_rsp_r"}, bus.rsp_r, 32'd0);
        chk1({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        chk32({tag, "_alu_a"}, bus.alu_a, 32'd0);
        chk32({tag, "_alu_b"}, bus.alu_b, 32'd0);
        chk32({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    // Scoreboard monitor: checks ALU drive in the issue cycle and every response
    bit seen = 0;
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else begin
            if (sb.size() > 0 && cyc == sb[0].acc + 1) begin
                chk32("alu_a", bus.alu_a, sb[0].a);
                chk32("alu_b", bus.alu_b, sb[0].b);
                chk32("alu_op", 32'(bus.alu_op), 32'(sb[0].op));
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: rsp0_valid=%0b rsp1_valid=%0b with nothing outstanding (cycle %0d)",
                             bus.rsp0_valid, bus.rsp1_valid, cyc);
                end else begin
                    if (!seen) begin
                        chk32("rsp_latency_cycle", 32'(cyc), 32'(sb[0].acc + 2));
                        seen = 1;
                    end
                    chk1("rsp0_valid", bus.rsp0_valid, sb[0].port == 0);
                    chk1("rsp1_valid", bus.rsp1_valid, sb[0].port == 1);
                    chk32("rsp_r", bus.rsp_r, sb[0].r);
                    chk1("rsp_err", bus.rsp_err, sb[0].err);
                    chk1("busy_in_resp", bus.busy, 1'b1);
                    if ((sb[0].port == 0 && bus.rsp0_ready) || (sb[0].port == 1 && bus.rsp1_ready)) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        pv = '{0, 0};
        gen_left = '{0, 0};
        pa = '{0, 0}; pb = '{0, 0}; pop = '{0, 0};

        // reset with a request already presented: no ready until reset drops
        set_req(0, 32'd5, 32'd7, 4'd0);
        step_rst(1'b1);
        step_rst(1'b1);
        chk_reset_outs("reset");

        // ADD 5+7 on port 0
        run_until_idle("add", 20);

        // both valid continuously: SUB on port 0, OR on port 1
        gen = 1;
        gen_left = '{4, 4};
        run_until_idle("alternate", 100);
        gen = 0;

        // owner holds off its ready for 5 RESP cycles while the other waits
        hold = 5;
        set_req(0, 32'd100, 32'd1, 4'd1);
        set_req(1, 32'd3, 32'd4, 4'd0);
        run_until_idle("hold", 60);
        hold = 0;

        // illegal op, then a tie to show the pointer moved
        set_req(0, 32'd9, 32'd9, 4'hC);
        run_until_idle("illegal", 20);
        set_req(0, 32'h8000_0000, 32'd4, 4'd7);
        set_req(1, 32'hFFFF_FFFE, 32'd1, 4'd8);
        run_until_idle("after_illegal", 40);

        // reset during ISSUE aborts the operation
        set_req(1, 32'd1, 32'd2, 4'd0);
        begin
            int n = 0;
            while (!outst && n < 10) begin
                step();
                n++;
            end
        end
        step_rst(1'b1);
        step();
        chk_reset_outs("abort");
        set_req(0, 32'd20, 32'd6, 4'd1);
        set_req(1, 32'd20, 32'd6, 4'd2);
        run_until_idle("post_abort", 40);

        // randomized traffic with random response back-pressure
        gen = 2;
        rand_rdy = 1;
        gen_left = '{60, 60};
        run_until_idle("random", 4000);
        gen = 0;
        rand_rdy = 0;

        repeat (3) step();
        chk32("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
